// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared types and constants for the pipeline hazard controller:
//   - hz_state_e      : branch-resolution FSM state encoding
//   - sb_cnt_width()  : width of one scoreboard down-counter for a load latency
//   - fcnt_width()    : width of the flush-window counter for a flush length
//   - OPC_*           : RV32 major opcodes the upstream decode uses to derive
//                       id_is_load / id_is_branch
// -----------------------------------------------------------------------------
package hazard_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BR_WAIT  = 2'd1,
        BR_FLUSH = 2'd2
    } hz_state_e;

    localparam int unsigned LOAD_LAT_MAX  = 7;
    localparam int unsigned FLUSH_CYC_MAX = 3;

    localparam logic [31:0] STALL_CNT_MAX = 32'hFFFF_FFFF;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    // A counter must be able to hold the value it is loaded with.
    function automatic int sb_cnt_width(input int load_lat);
        return $clog2(load_lat + 1);
    endfunction

    function automatic int fcnt_width(input int flush_cyc);
        return $clog2(flush_cyc + 1);
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
// Per-register load scoreboard. Each architectural register (except x0) owns a
// down-counter that is loaded with LOAD_LAT when a load targeting it issues and
// then counts down to zero every cycle, independent of pipeline stalls.
// A source operand that is read while its counter is nonzero is a load-use
// hazard.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   valid_i           ID holds a real instruction
//   rs1_i, rs2_i      ID source registers
//   rs1_used_i,
//   rs2_used_i        source operand is actually read
//   ld_issue_i        a load with a nonzero rd issues this cycle
//   ld_rd_i           destination of that load
//   luh_o             load-use hazard on the current ID instruction
// -----------------------------------------------------------------------------
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NREG     = 32,
    parameter int RAW      = 5,
    parameter int LOAD_LAT = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           valid_i,
    input  logic [RAW-1:0] rs1_i,
    input  logic           rs1_used_i,
    input  logic [RAW-1:0] rs2_i,
    input  logic           rs2_used_i,
    input  logic           ld_issue_i,
    input  logic [RAW-1:0] ld_rd_i,
    output logic           luh_o
);

    localparam int CW = sb_cnt_width(LOAD_LAT);
    localparam logic [CW-1:0] LAT_INIT = CW'(LOAD_LAT);

    logic [CW-1:0] cnt_q [NREG];
    logic          rs1_hit;
    logic          rs2_hit;

    // Entry 0 is reset and never written again, so x0 can never look busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (ld_issue_i && (ld_rd_i == RAW'(i))) begin
                    cnt_q[i] <= LAT_INIT;
                end else if (cnt_q[i] != '0) begin
                    cnt_q[i] <= cnt_q[i] - CW'(1);
                end
            end
        end
    end

    always_comb begin
        rs1_hit = rs1_used_i && (rs1_i != '0) && (cnt_q[rs1_i] != '0);
        rs2_hit = rs2_used_i && (rs2_i != '0) && (cnt_q[rs2_i] != '0);
        luh_o   = valid_i && (rs1_hit || rs2_hit);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Pipeline hazard controller beside the ID stage. Stalls on load-use hazards
// tracked by a per-register scoreboard, holds fetch while a branch is pending
// in EX and clears the wrong path for FLUSH_CYC cycles after a taken branch.
// Also counts load-use stall cycles (saturating) for performance monitoring.
//
// Parameters:
//   NREG (32), RAW (5 = clog2(NREG)), LOAD_LAT (1..7), FLUSH_CYC (1..3)
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   id_valid                 ID holds a real instruction
//   id_rs1, id_rs2           ID source registers
//   id_rs1_used, id_rs2_used source operand is actually read
//   id_rd                    ID destination register
//   id_is_load, id_is_branch ID instruction class
//   ex_br_resolved           branch in EX resolved this cycle
//   ex_br_taken              resolved branch was taken
//   pc_write, ifid_write     PC / IF-ID register enables
//   idex_flush, if_flush     bubble into ID/EX, clear IF/ID
//   stall_cycles             saturating count of load-use stall cycles
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | normal issue; load-use hazards stall here
// BR_WAIT  | branch issued, waiting for EX to resolve it; fetch held
// BR_FLUSH | taken branch: PC redirected, IF/ID cleared for FLUSH_CYC cycles
// -----------------------------------------------------------------------------
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int NREG      = 32,
    parameter int RAW       = 5,
    parameter int LOAD_LAT  = 1,
    parameter int FLUSH_CYC = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           id_valid,
    input  logic [RAW-1:0] id_rs1,
    input  logic [RAW-1:0] id_rs2,
    input  logic           id_rs1_used,
    input  logic           id_rs2_used,
    input  logic [RAW-1:0] id_rd,
    input  logic           id_is_load,
    input  logic           id_is_branch,
    input  logic           ex_br_resolved,
    input  logic           ex_br_taken,
    output logic           pc_write,
    output logic           ifid_write,
    output logic           idex_flush,
    output logic           if_flush,
    output logic [31:0]    stall_cycles
);

    localparam int FW = fcnt_width(FLUSH_CYC);
    localparam logic [FW-1:0] FLUSH_INIT = FW'(FLUSH_CYC);

    hz_state_e   state_q, state_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    logic luh;
    logic issue;
    logic ld_issue;

    // Issue is only possible in IDLE; instructions seen during a branch
    // window are wrong-path and must not touch the scoreboard.
    assign issue    = id_valid && !luh && (state_q == IDLE);
    assign ld_issue = issue && id_is_load && (id_rd != '0);

    hazard_scoreboard #(
        .NREG     (NREG),
        .RAW      (RAW),
        .LOAD_LAT (LOAD_LAT)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .valid_i    (id_valid),
        .rs1_i      (id_rs1),
        .rs1_used_i (id_rs1_used),
        .rs2_i      (id_rs2),
        .rs2_used_i (id_rs2_used),
        .ld_issue_i (ld_issue),
        .ld_rd_i    (id_rd),
        .luh_o      (luh)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            fcnt_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            fcnt_q      <= fcnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        fcnt_d     = fcnt_q;
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        idex_flush = 1'b0;
        if_flush   = 1'b0;

        case (state_q)
            IDLE: begin
                if (luh) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    idex_flush = 1'b1;
                end else if (issue && id_is_branch) begin
                    state_d = BR_WAIT;
                end
            end
            BR_WAIT: begin
                // IF/ID stays writable so the cleared entry is latched as a bubble.
                pc_write   = 1'b0;
                idex_flush = 1'b1;
                if_flush   = 1'b1;
                if (ex_br_resolved) begin
                    if (ex_br_taken) begin
                        state_d = BR_FLUSH;
                        fcnt_d  = FLUSH_INIT;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            BR_FLUSH: begin
                idex_flush = 1'b1;
                if_flush   = 1'b1;
                fcnt_d     = fcnt_q - FW'(1);
                if (fcnt_q == FW'(1)) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((state_q == IDLE) && luh && (stall_cnt_q != STALL_CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
// Two controller instances: dut0 (LOAD_LAT=1, FLUSH_CYC=2) and
// dut1 (LOAD_LAT=3, FLUSH_CYC=1). Each directed step drives one instance
// (the other sees an idle ID stage), queues the expected outputs and
// compares them on the falling edge of the same cycle.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

    typedef struct packed {
        logic       v;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic [4:0] rd;
        logic       ld;
        logic       br;
        logic       res;
        logic       tk;
    } stim_t;

    typedef struct {
        string       tag;
        int          d;
        bit          is_cnt;
        logic [31:0] val;
    } exp_t;

    localparam logic [3:0] O_RUN   = 4'b1100;
    localparam logic [3:0] O_STALL = 4'b0010;
    localparam logic [3:0] O_WAIT  = 4'b0111;
    localparam logic [3:0] O_FLUSH = 4'b1111;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    stim_t s0  = '0;
    stim_t s1  = '0;

    logic        pcw0, ifw0, idf0, iff0;
    logic        pcw1, ifw1, idf1, iff1;
    logic [31:0] cnt0, cnt1;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.NREG(32), .RAW(5), .LOAD_LAT(1), .FLUSH_CYC(2)) dut0 (
        .clk(clk), .rst(rst), .id_valid(s0.v),
        .id_rs1(s0.rs1), .id_rs2(s0.rs2),
        .id_rs1_used(s0.u1), .id_rs2_used(s0.u2),
        .id_rd(s0.rd), .id_is_load(s0.ld), .id_is_branch(s0.br),
        .ex_br_resolved(s0.res), .ex_br_taken(s0.tk),
        .pc_write(pcw0), .ifid_write(ifw0), .idex_flush(idf0), .if_flush(iff0),
        .stall_cycles(cnt0)
    );

    hazard_ctrl #(.NREG(32), .RAW(5), .LOAD_LAT(3), .FLUSH_CYC(1)) dut1 (
        .clk(clk), .rst(rst), .id_valid(s1.v),
        .id_rs1(s1.rs1), .id_rs2(s1.rs2),
        .id_rs1_used(s1.u1), .id_rs2_used(s1.u2),
        .id_rd(s1.rd), .id_is_load(s1.ld), .id_is_branch(s1.br),
        .ex_br_resolved(s1.res), .ex_br_taken(s1.tk),
        .pc_write(pcw1), .ifid_write(ifw1), .idex_flush(idf1), .if_flush(iff1),
        .stall_cycles(cnt1)
    );

    function automatic stim_t f_nop();
        stim_t s = '0;
        return s;
    endfunction

    // lw rd, 0(x1)
    function automatic stim_t f_ld(input logic [4:0] rd);
        stim_t s = '0;
        s.v = 1'b1; s.ld = 1'b1; s.rd = rd; s.rs1 = 5'd1; s.u1 = 1'b1;
        return s;
    endfunction

    function automatic stim_t f_alu(input logic [4:0] rd, input logic [4:0] rs1,
                                    input logic [4:0] rs2, input logic u2);
        stim_t s = '0;
        s.v = 1'b1; s.rd = rd; s.rs1 = rs1; s.u1 = 1'b1; s.rs2 = rs2; s.u2 = u2;
        return s;
    endfunction

    function automatic stim_t f_br(input logic [4:0] rs1, input logic u1);
        stim_t s = '0;
        s.v = 1'b1; s.br = 1'b1; s.rs1 = rs1; s.u1 = u1;
        return s;
    endfunction

    function automatic stim_t f_res(input logic tk);
        stim_t s = '0;
        s.res = 1'b1; s.tk = tk;
        return s;
    endfunction

    task automatic drive(input int d, input stim_t st);
        if (d == 0) begin
            s0 = st; s1 = '0;
        end else begin
            s1 = st; s0 = '0;
        end
    endtask

    task automatic exp_out(input string tag, input int d, input logic [3:0] o);
        exp_t e;
        e.tag = tag; e.d = d; e.is_cnt = 1'b0; e.val = {28'd0, o};
        q.push_back(e);
    endtask

    task automatic exp_cnt(input string tag, input int d, input logic [31:0] v);
        exp_t e;
        e.tag = tag; e.d = d; e.is_cnt = 1'b1; e.val = v;
        q.push_back(e);
    endtask

    task automatic check_now();
        exp_t        e;
        logic [31:0] obs;
        while (q.size() > 0) begin
            e = q.pop_front();
            if (e.is_cnt) obs = (e.d == 0) ? cnt0 : cnt1;
            else          obs = (e.d == 0) ? {28'd0, pcw0, ifw0, idf0, iff0}
                                           : {28'd0, pcw1, ifw1, idf1, iff1};
            n_checks++;
            assert (obs === e.val) else begin
                n_errors++;
                $error("FAIL %s dut%0d: observed %h expected %h", e.tag, e.d, obs, e.val);
            end
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        check_now();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input int d, input stim_t st, input logic [3:0] o, input string tag);
        drive(d, st);
        exp_out(tag, d, o);
        cyc();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // reset values
        @(posedge clk); #1;
        exp_out("rst_out", 0, O_RUN);
        exp_out("rst_out", 1, O_RUN);
        exp_cnt("rst_cnt", 0, 32'd0);
        exp_cnt("rst_cnt", 1, 32'd0);
        cyc();
        rst = 1'b0;

        // dut0, LOAD_LAT=1: load x5, add x6,x5,x1
        step(0, f_ld(5'd5),                    O_RUN,   "l1_load");
        step(0, f_alu(5'd6, 5'd5, 5'd1, 1'b1), O_STALL, "l1_stall");
        step(0, f_alu(5'd6, 5'd5, 5'd1, 1'b1), O_RUN,   "l1_issue");
        exp_cnt("l1_cnt", 0, 32'd1);
        step(0, f_nop(),                       O_RUN,   "l1_nop");

        // x0 is never tracked
        step(0, f_ld(5'd0),                    O_RUN,   "x0_load");
        step(0, f_alu(5'd6, 5'd0, 5'd1, 1'b1), O_RUN,   "x0_use");
        // rs2 not used -> no hazard; rs2 used -> hazard
        step(0, f_ld(5'd7),                    O_RUN,   "x7_load");
        step(0, f_alu(5'd6, 5'd1, 5'd7, 1'b0), O_RUN,   "x7_unused");
        step(0, f_ld(5'd9),                    O_RUN,   "x9_load");
        step(0, f_alu(5'd6, 5'd1, 5'd9, 1'b1), O_STALL, "x9_rs2_stall");
        step(0, f_alu(5'd6, 5'd1, 5'd9, 1'b1), O_RUN,   "x9_rs2_issue");

        // dut0, FLUSH_CYC=2: taken branch, load in BR_WAIT is dropped
        step(0, f_br(5'd0, 1'b0),              O_RUN,   "bt_issue");
        step(0, f_ld(5'd12),                   O_WAIT,  "bt_wait1");
        step(0, f_res(1'b1),                   O_WAIT,  "bt_wait2");
        step(0, f_nop(),                       O_FLUSH, "bt_flush1");
        step(0, f_nop(),                       O_FLUSH, "bt_flush2");
        begin
            stim_t st = f_alu(5'd13, 5'd12, 5'd1, 1'b1);
            st.res = 1'b1; st.tk = 1'b1;       // resolve ignored in IDLE
            step(0, st,                        O_RUN,   "bt_idle");
        end
        step(0, f_nop(),                       O_RUN,   "bt_res_ignored");

        // not-taken resolve
        step(0, f_br(5'd0, 1'b0),              O_RUN,   "bn_issue");
        step(0, f_nop(),                       O_WAIT,  "bn_wait1");
        step(0, f_res(1'b0),                   O_WAIT,  "bn_wait2");
        step(0, f_nop(),                       O_RUN,   "bn_idle");

        // branch blocked by load-use hazard
        step(0, f_ld(5'd3),                    O_RUN,   "bb_load");
        step(0, f_br(5'd3, 1'b1),              O_STALL, "bb_stall");
        step(0, f_br(5'd3, 1'b1),              O_RUN,   "bb_issue");
        step(0, f_nop(),                       O_WAIT,  "bb_wait");
        step(0, f_res(1'b0),                   O_WAIT,  "bb_resolve");
        exp_cnt("d0_cnt", 0, 32'd3);
        step(0, f_nop(),                       O_RUN,   "bb_idle");

        // dut1, LOAD_LAT=3
        step(1, f_ld(5'd5),                    O_RUN,   "l3_load");
        step(1, f_alu(5'd6, 5'd5, 5'd1, 1'b1), O_STALL, "l3_stall1");
        step(1, f_alu(5'd6, 5'd5, 5'd1, 1'b1), O_STALL, "l3_stall2");
        step(1, f_alu(5'd6, 5'd5, 5'd1, 1'b1), O_STALL, "l3_stall3");
        step(1, f_alu(5'd6, 5'd5, 5'd1, 1'b1), O_RUN,   "l3_issue");
        exp_cnt("l3_cnt", 1, 32'd3);
        step(1, f_nop(),                       O_RUN,   "l3_nop");
        // consumer arriving at t+4
        step(1, f_ld(5'd5),                    O_RUN,   "l3_load_b");
        step(1, f_nop(),                       O_RUN,   "l3_gap1");
        step(1, f_nop(),                       O_RUN,   "l3_gap2");
        step(1, f_nop(),                       O_RUN,   "l3_gap3");
        step(1, f_alu(5'd6, 5'd5, 5'd1, 1'b1), O_RUN,   "l3_late_use");

        // dut1, FLUSH_CYC=1
        step(1, f_br(5'd0, 1'b0),              O_RUN,   "f1_issue");
        step(1, f_res(1'b1),                   O_WAIT,  "f1_wait");
        step(1, f_nop(),                       O_FLUSH, "f1_flush");
        step(1, f_nop(),                       O_RUN,   "f1_idle");

        // async reset during BR_WAIT with cnt[x5] nonzero
        step(1, f_ld(5'd5),                    O_RUN,   "ar_load");
        step(1, f_br(5'd0, 1'b0),              O_RUN,   "ar_branch");
        step(1, f_nop(),                       O_WAIT,  "ar_wait");
        drive(1, f_nop());
        rst = 1'b1;
        #1;
        exp_out("ar_out", 1, O_RUN);
        exp_out("ar_out", 0, O_RUN);
        exp_cnt("ar_cnt", 0, 32'd0);
        check_now();
        @(posedge clk); #1;
        rst = 1'b0;
        step(1, f_alu(5'd6, 5'd5, 5'd1, 1'b1), O_RUN,   "ar_use");

        // saturation of stall_cycles
        force dut1.stall_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut1.stall_cnt_q;
        exp_cnt("sat_preset", 1, 32'hFFFF_FFFE);
        step(1, f_ld(5'd5),                    O_RUN,   "sat_load");
        step(1, f_alu(5'd6, 5'd5, 5'd1, 1'b1), O_STALL, "sat_stall1");
        exp_cnt("sat_cnt1", 1, 32'hFFFF_FFFF);
        step(1, f_alu(5'd6, 5'd5, 5'd1, 1'b1), O_STALL, "sat_stall2");
        step(1, f_alu(5'd6, 5'd5, 5'd1, 1'b1), O_STALL, "sat_stall3");
        step(1, f_alu(5'd6, 5'd5, 5'd1, 1'b1), O_RUN,   "sat_issue");
        exp_cnt("sat_hold", 1, 32'hFFFF_FFFF);
        step(1, f_nop(),                       O_RUN,   "sat_nop");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
